pc_sequencer: RTL and testbench

//  Owns the processor PC register and decides, once per cycle, whether the PC advances, takes a redirect, or holds.

---
 rtl/pc_seq_pkg.sv | 16 +
 rtl/md_wait_timer.sv | 30 +++
 rtl/pc_sequencer.sv | 115 +++++++++++
 tb/tb_pc_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared state encoding and sizing helper for pc_sequencer
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MD_ISSUE = 2'd2,
    MD_WAIT  = 2'd3
  } state_t;

  // Width needed to count 0 .. max_cycles-1.
  function automatic int clog2(input int max_cycles);
    return (max_cycles <= 2) ? 1 : $clog2(max_cycles);
  endfunction

endpackage

// File: rtl/md_wait_timer.sv
// rtl/md_wait_timer.sv - mult/div wait counter with expiry flag at MD_TIMEOUT-1
module md_wait_timer
  import pc_seq_pkg::*;
#(
  parameter int MD_TIMEOUT = 40
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TMR_W = clog2(MD_TIMEOUT);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + {{(TMR_W-1){1'b0}}, 1'b1};
    end
  end

  assign expired = enable && (count == TMR_W'(MD_TIMEOUT - 1));

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC register, fetch sequencing and mult/div issue; PC_SEQ_PERF_EN adds perf counters
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_W       = 12,
  parameter int RESET_PC   = 0,
  parameter int MD_TIMEOUT = 40
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_target,
  input  logic            md_req,
  input  logic            md_is_div,
  input  logic            md_result_rdy,
  input  logic            halt,
  output logic [PC_W-1:0] address_imem,
  output logic [PC_W-1:0] pc_plus_1,
  output logic            commit_en,
  output logic            ctrl_MULT,
  output logic            ctrl_DIV,
  output logic            md_timeout
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [31:0]     perf_retired,
  output logic [31:0]     perf_redirects
`endif
);

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] next_pc;
  logic            tmr_expired;

  assign address_imem = pc;
  assign pc_plus_1    = pc + {{(PC_W-1){1'b0}}, 1'b1};

  md_wait_timer #(
    .MD_TIMEOUT(MD_TIMEOUT)
  ) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (state == MD_ISSUE),
    .enable (state == MD_WAIT),
    .expired(tmr_expired)
  );

  // Commit and next-PC depend on this cycle's decode, so they are decoded combinationally.
  always_comb begin
    commit_en  = 1'b0;
    md_timeout = 1'b0;
    next_pc    = pc;
    case (state)
      RUN: begin
        if (!halt && !md_req) begin
          commit_en = 1'b1;
          next_pc   = redirect_valid ? redirect_target : pc_plus_1;
        end
      end
      MD_WAIT: begin
        if (md_result_rdy) begin
          commit_en = 1'b1;
          next_pc   = pc_plus_1;
        end else if (tmr_expired) begin
          md_timeout = 1'b1;
          next_pc    = pc_plus_1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= BOOT;
      pc        <= PC_W'(RESET_PC);
      ctrl_MULT <= 1'b0;
      ctrl_DIV  <= 1'b0;
    end else begin
      pc        <= next_pc;
      ctrl_MULT <= 1'b0;
      ctrl_DIV  <= 1'b0;
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (!halt && md_req) begin
            state     <= MD_ISSUE;
            ctrl_DIV  <= md_is_div;
            ctrl_MULT <= ~md_is_div;
          end
        end
        MD_ISSUE: state <= MD_WAIT;
        MD_WAIT: begin
          if (md_result_rdy || tmr_expired) state <= RUN;
        end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef PC_SEQ_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_retired   <= '0;
      perf_redirects <= '0;
    end else begin
      if (commit_en) perf_retired <= perf_retired + 32'd1;
      if (commit_en && state == RUN && redirect_valid) perf_redirects <= perf_redirects + 32'd1;
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer against a behavioural model
module tb_pc_sequencer;

  localparam int MD_TO = 40;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [11:0] redirect_target = '0;
  logic        md_req = 1'b0;
  logic        md_is_div = 1'b0;
  logic        md_result_rdy = 1'b0;
  logic        halt = 1'b0;
  logic [11:0] address_imem, pc_plus_1;
  logic        commit_en, ctrl_MULT, ctrl_DIV, md_timeout;
`ifdef PC_SEQ_PERF_EN
  logic [31:0] perf_retired, perf_redirects;
`endif

  always #5 clock = ~clock;

  pc_sequencer #(.PC_W(12), .RESET_PC(0), .MD_TIMEOUT(MD_TO)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .md_req         (md_req),
    .md_is_div      (md_is_div),
    .md_result_rdy  (md_result_rdy),
    .halt           (halt),
    .address_imem   (address_imem),
    .pc_plus_1      (pc_plus_1),
    .commit_en      (commit_en),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .md_timeout     (md_timeout)
`ifdef PC_SEQ_PERF_EN
    ,
    .perf_retired   (perf_retired),
    .perf_redirects (perf_redirects)
`endif
  );

  logic [27:0] obs;
  assign obs = {address_imem, pc_plus_1, commit_en, ctrl_MULT, ctrl_DIV, md_timeout};

  int passed = 0;
  int total = 0;

  // Model: pc as an integer, boot/issue flags and a count of cycles spent waiting (-1 = not waiting).
  int m_pc, n_pc, m_wait, n_wait;
  bit m_boot, n_boot, m_issue, n_issue, m_div, n_div;
  logic [27:0] e_vec;

  task automatic model_reset();
    m_pc = 0; m_boot = 1; m_issue = 0; m_div = 0; m_wait = -1;
  endtask

  task automatic model_eval();
    bit c, mu, dv, to;
    c = 0; mu = 0; dv = 0; to = 0;
    n_pc = m_pc; n_boot = 0; n_issue = 0; n_div = m_div; n_wait = m_wait;
    if (m_boot) begin
    end else if (m_issue) begin
      mu = !m_div; dv = m_div; n_wait = 0;
    end else if (m_wait >= 0) begin
      if (md_result_rdy) begin
        c = 1; n_pc = (m_pc + 1) % 4096; n_wait = -1;
      end else if (m_wait == MD_TO - 1) begin
        to = 1; n_pc = (m_pc + 1) % 4096; n_wait = -1;
      end else begin
        n_wait = m_wait + 1;
      end
    end else if (halt) begin
    end else if (md_req) begin
      n_issue = 1; n_div = md_is_div;
    end else if (redirect_valid) begin
      c = 1; n_pc = int'(redirect_target);
    end else begin
      c = 1; n_pc = (m_pc + 1) % 4096;
    end
    e_vec = {12'(m_pc), 12'((m_pc + 1) % 4096), c, mu, dv, to};
  endtask

  task automatic apply(input bit rv, input logic [11:0] tgt, input bit req, input bit dv,
                       input bit rdy, input bit hlt);
    @(negedge clock);
    redirect_valid = rv; redirect_target = tgt; md_req = req;
    md_is_div = dv; md_result_rdy = rdy; halt = hlt;
    #1;
    model_eval();
  endtask

  task automatic advance();
    @(posedge clock);
    m_pc = n_pc; m_boot = n_boot; m_issue = n_issue; m_div = n_div; m_wait = n_wait;
  endtask

  task automatic test_reset();
    int ea[5] = '{0, 0, 1, 2, 3};
    bit ec[5] = '{0, 1, 1, 1, 1};
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    total++;
    if (obs !== {12'h000, 12'h001, 4'b0000}) $display("FAIL reset_state: got %h exp %h", obs, {12'h000, 12'h001, 4'b0000});
    else passed++;
    model_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      apply(0, '0, 0, 0, 0, 0);
      total++;
      if (address_imem !== 12'(ea[i]) || commit_en !== ec[i])
        $display("FAIL boot_seq[%0d]: got addr %h commit %b exp addr %h commit %b", i, address_imem, commit_en, 12'(ea[i]), ec[i]);
      else passed++;
      advance();
    end
  endtask

  task automatic test_redirect();
    while (m_pc != 5) begin
      apply(0, '0, 0, 0, 0, 0);
      advance();
    end
    apply(1, 12'h040, 0, 0, 0, 0);
    total++;
    if (obs !== e_vec || commit_en !== 1'b1) $display("FAIL redirect_commit: got %h exp %h", obs, e_vec);
    else passed++;
    advance();
    apply(0, '0, 0, 0, 0, 0);
    total++;
    if (address_imem !== 12'h040) $display("FAIL redirect_target: got %h exp %h", address_imem, 12'h040);
    else passed++;
    advance();
  endtask

  task automatic test_wrap();
    apply(1, 12'hFFF, 0, 0, 0, 0);
    advance();
    apply(0, '0, 0, 0, 0, 0);
    total++;
    if (address_imem !== 12'hFFF || pc_plus_1 !== 12'h000)
      $display("FAIL wrap_plus1: got addr %h p1 %h exp addr fff p1 000", address_imem, pc_plus_1);
    else passed++;
    advance();
    apply(0, '0, 0, 0, 0, 0);
    total++;
    if (address_imem !== 12'h000) $display("FAIL wrap_pc: got %h exp %h", address_imem, 12'h000);
    else passed++;
    advance();
  endtask

  task automatic test_div_rdy();
    int div_pulses, mult_pulses, bad;
    div_pulses = 0; mult_pulses = 0; bad = 0;
    apply(1, 12'h007, 0, 0, 0, 0);
    advance();
    apply(1, 12'h0AA, 1, 1, 1, 0);
    total++;
    if (obs !== e_vec || commit_en !== 1'b0) $display("FAIL div_req: got %h exp %h", obs, e_vec);
    else passed++;
    advance();
    for (int k = 0; k <= 17; k++) begin
      apply(0, '0, 0, 0, (k == 17), 0);
      div_pulses += int'(ctrl_DIV);
      mult_pulses += int'(ctrl_MULT);
      if (obs !== e_vec || (k < 17 && address_imem !== 12'h007)) bad++;
      if (k == 17) begin
        total++;
        if (commit_en !== 1'b1 || md_timeout !== 1'b0) $display("FAIL div_rdy_commit: got %h exp %h", obs, e_vec);
        else passed++;
      end
      advance();
    end
    total++;
    if (bad != 0) $display("FAIL div_wait_cycles: got %0d bad cycles exp 0", bad);
    else passed++;
    total++;
    if (div_pulses != 1 || mult_pulses != 0) $display("FAIL div_pulse: got div %0d mult %0d exp 1 0", div_pulses, mult_pulses);
    else passed++;
    apply(0, '0, 0, 0, 0, 0);
    total++;
    if (address_imem !== 12'h008) $display("FAIL div_next_pc: got %h exp %h", address_imem, 12'h008);
    else passed++;
    advance();
  endtask

  task automatic test_md_timeout(input bit late_rdy);
    int pc0, bad, mult_pulses;
    bad = 0; mult_pulses = 0;
    pc0 = m_pc;
    apply(0, '0, 1, 0, 0, 0);
    advance();
    for (int k = 0; k <= MD_TO; k++) begin
      apply(1, 12'h3C3, 0, 0, late_rdy && (k == MD_TO), 1);
      mult_pulses += int'(ctrl_MULT);
      if (obs !== e_vec) bad++;
      if (k == MD_TO) begin
        total++;
        if (md_timeout !== !late_rdy || commit_en !== late_rdy)
          $display("FAIL timeout_edge(rdy=%0d): got to %b commit %b exp to %b commit %b", late_rdy, md_timeout, commit_en, !late_rdy, late_rdy);
        else passed++;
      end else if (md_timeout !== 1'b0) begin
        bad++;
      end
      advance();
    end
    total++;
    if (bad != 0 || mult_pulses != 1) $display("FAIL mult_wait(rdy=%0d): got %0d bad, %0d pulses exp 0 bad, 1 pulse", late_rdy, bad, mult_pulses);
    else passed++;
    apply(0, '0, 0, 0, 0, 0);
    total++;
    if (address_imem !== 12'((pc0 + 1) % 4096)) $display("FAIL timeout_next_pc: got %h exp %h", address_imem, 12'((pc0 + 1) % 4096));
    else passed++;
    advance();
  endtask

  task automatic test_halt();
    int pc0;
    pc0 = m_pc;
    apply(1, 12'h123, 0, 0, 0, 1);
    total++;
    if (commit_en !== 1'b0 || obs !== e_vec) $display("FAIL halt_commit: got %h exp %h", obs, e_vec);
    else passed++;
    advance();
    apply(0, '0, 0, 0, 0, 0);
    total++;
    if (address_imem !== 12'(pc0)) $display("FAIL halt_hold: got %h exp %h", address_imem, 12'(pc0));
    else passed++;
    advance();
  endtask

  task automatic test_reset_mid_wait();
    apply(0, '0, 1, 1, 0, 0);
    advance();
    for (int k = 0; k < 6; k++) begin
      apply(0, '0, 0, 0, 0, 0);
      advance();
    end
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    total++;
    if (obs !== {12'h000, 12'h001, 4'b0000}) $display("FAIL reset_mid_wait: got %h exp %h", obs, {12'h000, 12'h001, 4'b0000});
    else passed++;
    model_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      apply(0, '0, 0, 0, 0, 0);
      total++;
      if (obs !== e_vec) $display("FAIL post_reset[%0d]: got %h exp %h", k, obs, e_vec);
      else passed++;
      advance();
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      apply(($urandom_range(0, 3) == 0), 12'($urandom), ($urandom_range(0, 7) == 0),
            1'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
      total++;
      if (obs !== e_vec) begin
        $display("FAIL random[%0d]: got %h exp %h", i, obs, e_vec);
        bad++;
      end else passed++;
      advance();
      if (bad > 10) break;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_redirect();
    test_wrap();
    test_div_rdy();
    test_md_timeout(1'b0);
    test_md_timeout(1'b1);
    test_halt();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
